// File: rtl/iot_event_arbiter.sv
// Round-robin arbiter that serialises device join/leave events into a single
// change/on_off stream for an occupancy counter, filtering redundant or over-capacity events.
module iot_event_arbiter #(
    parameter int N_DEV      = 4,
    parameter int MAX_ACTIVE = 255,
    parameter int GAP        = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_DEV-1:0] req,
    input  logic [N_DEV-1:0] req_on,
    output logic [N_DEV-1:0] ack,
    output logic             rejected,
    output logic             change,
    output logic             on_off,
    output logic [N_DEV-1:0] active_map,
    output logic [7:0]       active_count,
    output logic             busy
);
    localparam int         IW      = (N_DEV > 1) ? $clog2(N_DEV) : 1;
    localparam logic [7:0] MAX_CNT = 8'(MAX_ACTIVE);

    typedef enum logic [1:0] {IDLE, ISSUE, COOLDOWN} state_t;

    state_t           state_q, state_d;
    logic [N_DEV-1:0] pending_q, pending_d;
    logic [N_DEV-1:0] pend_dir_q, pend_dir_d;
    logic [N_DEV-1:0] active_map_q, active_map_d;
    logic [7:0]       count_q, count_d;
    logic [IW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]    grant_q, grant_d;
    logic [3:0]       gap_q, gap_d;

    logic [IW-1:0]    search_idx;
    logic             search_found;
    logic             cur_dir, cur_active, valid_join, valid_leave, valid_evt, in_issue;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            pending_q    <= '0;
            pend_dir_q   <= '0;
            active_map_q <= '0;
            count_q      <= '0;
            rr_ptr_q     <= '0;
            grant_q      <= '0;
            gap_q        <= '0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            pend_dir_q   <= pend_dir_d;
            active_map_q <= active_map_d;
            count_q      <= count_d;
            rr_ptr_q     <= rr_ptr_d;
            grant_q      <= grant_d;
            gap_q        <= gap_d;
        end
    end

    // First pending device at or after rr_ptr, wrapping modulo N_DEV.
    always_comb begin
        int idx;
        idx          = 0;
        search_found = 1'b0;
        search_idx   = '0;
        for (int k = 0; k < N_DEV; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= N_DEV) idx = idx - N_DEV;
            if (!search_found && pending_q[idx]) begin
                search_found = 1'b1;
                search_idx   = IW'(idx);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        gap_d    = gap_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            IDLE: begin
                if (search_found) begin
                    grant_d = search_idx;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                rr_ptr_d = (grant_q == IW'(N_DEV - 1)) ? '0 : grant_q + 1'b1;
                if (GAP > 0) begin
                    state_d = COOLDOWN;
                    gap_d   = 4'(GAP - 1);
                end else begin
                    state_d = IDLE;
                end
            end
            COOLDOWN: begin
                if (gap_q == 4'd0) state_d = IDLE;
                else               gap_d   = gap_q - 4'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Reset gates the ISSUE cycle so an aborted event never shows an ack.
    assign in_issue    = (state_q == ISSUE) && !rst;
    assign cur_dir     = pend_dir_q[grant_q];
    assign cur_active  = active_map_q[grant_q];
    assign valid_join  = cur_dir && !cur_active && (count_q < MAX_CNT);
    assign valid_leave = !cur_dir && cur_active;
    assign valid_evt   = valid_join || valid_leave;

    always_comb begin
        change   = in_issue && valid_evt;
        on_off   = in_issue && valid_evt && cur_dir;
        rejected = in_issue && !valid_evt;
        count_d  = count_q;
        if (in_issue && valid_join)       count_d = count_q + 8'd1;
        else if (in_issue && valid_leave) count_d = count_q - 8'd1;
    end

    // A request arriving in the grant cycle survives the clear and carries its new direction.
    generate
        for (genvar gi = 0; gi < N_DEV; gi++) begin : g_dev
            assign ack[gi]          = in_issue && (grant_q == IW'(gi));
            assign pending_d[gi]    = req[gi] | (pending_q[gi] & ~ack[gi]);
            assign pend_dir_d[gi]   = req[gi] ? req_on[gi] : pend_dir_q[gi];
            assign active_map_d[gi] = (ack[gi] && valid_evt) ? cur_dir : active_map_q[gi];
        end
    endgenerate

    assign active_map   = active_map_q;
    assign active_count = count_q;
    assign busy         = (|pending_q) || (state_q != IDLE);

endmodule
